// File: rtl/memory_access_pipeline.sv
// In-order memory access pipeline: circular buffer of in-flight instructions with per-opcode
// latency countdown, retiring the head over a valid/ready done channel.
module memory_access_pipeline #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int OPCODE_LENGTH      = 8,
    parameter logic [OPCODE_LENGTH-1:0] LOAD_OPCODE = 8'h01,
    parameter int LOAD_LATENCY       = 4,
    parameter int STORE_LATENCY      = 2,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int TAG_WIDTH          = 4,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction_i,
    input  logic                          instruction_valid_i,
    output logic                          ready_o,
    output logic                          done_valid_o,
    input  logic                          done_ready_i,
    output logic [INSTRUCTION_LENGTH-1:0] done_instruction_o,
    output logic [TAG_WIDTH-1:0]          done_tag_o,
    output logic [OW-1:0]                 outstanding_o,
    output logic                          busy_o
);
    localparam int MAXLAT = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam int PW     = $clog2(MAX_OUTSTANDING);
    localparam logic [CW-1:0] LOAD_REM  = CW'(LOAD_LATENCY - 1);
    localparam logic [CW-1:0] STORE_REM = CW'(STORE_LATENCY - 1);

    logic [MAX_OUTSTANDING-1:0]                         slot_vld_q, slot_vld_d;
    logic [MAX_OUTSTANDING-1:0][INSTRUCTION_LENGTH-1:0] slot_instr_q, slot_instr_d;
    logic [MAX_OUTSTANDING-1:0][TAG_WIDTH-1:0]          slot_tag_q, slot_tag_d;
    logic [MAX_OUTSTANDING-1:0][CW-1:0]                 slot_rem_q, slot_rem_d;
    logic [PW-1:0]                 head_q, head_d, tail_q, tail_d, nxt_head;
    logic [TAG_WIDTH-1:0]          tag_cnt_q, tag_cnt_d;
    logic [OW-1:0]                 count_q, count_d;
    logic                          ready_q, ready_d, busy_q, busy_d;
    logic                          done_valid_q, done_valid_d;
    logic [INSTRUCTION_LENGTH-1:0] done_instr_q, done_instr_d;
    logic [TAG_WIDTH-1:0]          done_tag_q, done_tag_d;
    logic                          accept, retire;

    assign accept = instruction_valid_i & ready_q;
    assign retire = done_valid_q & done_ready_i;

    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_instr_d = slot_instr_q;
        slot_tag_d   = slot_tag_q;
        slot_rem_d   = slot_rem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        tag_cnt_d    = tag_cnt_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (slot_vld_q[i] && slot_rem_q[i] != '0) slot_rem_d[i] = slot_rem_q[i] - CW'(1);
        end
        if (retire) begin
            slot_vld_d[head_q] = 1'b0;
            head_d             = head_q + PW'(1);
        end
        if (accept) begin
            slot_vld_d[tail_q]   = 1'b1;
            slot_instr_d[tail_q] = instruction_i;
            slot_tag_d[tail_q]   = tag_cnt_q;
            slot_rem_d[tail_q]   = (instruction_i[OPCODE_LENGTH-1:0] == LOAD_OPCODE) ? LOAD_REM : STORE_REM;
            tail_d               = tail_q + PW'(1);
            tag_cnt_d            = tag_cnt_q + TAG_WIDTH'(1);
        end
        count_d = count_q + OW'(accept) - OW'(retire);
        ready_d = (count_d != OW'(MAX_OUTSTANDING));
        busy_d  = (count_d != '0);
        // Present the slot that will be head after this edge, so back-to-back retires have no bubble.
        nxt_head     = retire ? head_q + PW'(1) : head_q;
        done_valid_d = slot_vld_q[nxt_head] && (slot_rem_q[nxt_head] == '0);
        done_instr_d = slot_instr_q[nxt_head];
        done_tag_d   = slot_tag_q[nxt_head];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_vld_q   <= '0;
            slot_instr_q <= '0;
            slot_tag_q   <= '0;
            slot_rem_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            tag_cnt_q    <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
            done_instr_q <= '0;
            done_tag_q   <= '0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_instr_q <= slot_instr_d;
            slot_tag_q   <= slot_tag_d;
            slot_rem_q   <= slot_rem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            tag_cnt_q    <= tag_cnt_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_valid_q <= done_valid_d;
            done_instr_q <= done_instr_d;
            done_tag_q   <= done_tag_d;
        end
    end

    assign ready_o            = ready_q;
    assign busy_o             = busy_q;
    assign outstanding_o      = count_q;
    assign done_valid_o       = done_valid_q;
    assign done_instruction_o = done_instr_q;
    assign done_tag_o         = done_tag_q;
endmodule

// File: tb/tb_memory_access_pipeline.sv
// Directed bench for memory_access_pipeline: cycle table for latency/order/backpressure,
// hand sequences for streaming, tag wrap and mid-flight reset.
module tb_memory_access_pipeline;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [31:0] instruction_i = '0;
    logic        instruction_valid_i = 1'b0;
    logic        ready_o, done_valid_o, busy_o;
    logic        done_ready_i = 1'b0;
    logic [31:0] done_instruction_o;
    logic [3:0]  done_tag_o;
    logic [2:0]  outstanding_o;

    int errs = 0;
    int checks = 0;

    memory_access_pipeline dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .instruction_i(instruction_i),
        .instruction_valid_i(instruction_valid_i), .ready_o(ready_o),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_instruction_o(done_instruction_o), .done_tag_o(done_tag_o),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [31:0] instr;
        bit          drdy;
        bit          e_dv;
        logic [3:0]  e_tag;
        logic [31:0] e_instr;
        logic [2:0]  e_out;
        bit          e_rdy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        instruction_valid_i = 1'b0;
        done_ready_i        = 1'b0;
        reset_n_i           = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    task automatic add(input bit rst, input bit vld, input logic [31:0] instr, input bit drdy,
                       input bit e_dv, input logic [3:0] e_tag, input logic [31:0] e_instr,
                       input logic [2:0] e_out, input bit e_rdy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.instr = instr; v.drdy = drdy; v.e_dv = e_dv;
        v.e_tag = e_tag; v.e_instr = e_instr; v.e_out = e_out; v.e_rdy = e_rdy;
        tbl.push_back(v);
    endtask

    initial begin
        int exp_tag;
        int retired;
        bit seen;

        // Single load: done visible after 4th edge, one cycle, then empty.
        add(1, 1, 32'h0000_AB01, 1, 0, 0, 0,            1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            1, 1);
        add(0, 0, 0,             1, 1, 0, 32'h0000_AB01, 1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            0, 1);
        // Load then store: store completes first but retires right after the load.
        add(1, 1, 32'h0000_AB01, 1, 0, 0, 0,            1, 1);
        add(0, 1, 32'h0000_CD02, 1, 0, 0, 0,            2, 1);
        add(0, 0, 0,             1, 0, 0, 0,            2, 1);
        add(0, 0, 0,             1, 0, 0, 0,            2, 1);
        add(0, 0, 0,             1, 1, 0, 32'h0000_AB01, 2, 1);
        add(0, 0, 0,             1, 1, 1, 32'h0000_CD02, 1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            0, 1);
        // Fill with backpressure, 5th issue dropped, then drain one per cycle.
        add(1, 1, 32'h0000_1002, 0, 0, 0, 0,            1, 1);
        add(0, 1, 32'h0000_1102, 0, 0, 0, 0,            2, 1);
        add(0, 1, 32'h0000_1202, 0, 1, 0, 32'h0000_1002, 3, 1);
        add(0, 1, 32'h0000_1302, 0, 1, 0, 32'h0000_1002, 4, 0);
        add(0, 1, 32'h0000_1402, 0, 1, 0, 32'h0000_1002, 4, 0);
        add(0, 0, 0,             1, 1, 1, 32'h0000_1102, 3, 1);
        add(0, 0, 0,             1, 1, 2, 32'h0000_1202, 2, 1);
        add(0, 0, 0,             1, 1, 3, 32'h0000_1302, 1, 1);
        add(0, 0, 0,             1, 0, 0, 0,            0, 1);
        add(0, 0, 0,             1, 0, 0, 0,            0, 1);

        // Reset state.
        do_reset();
        #1;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_done_valid", 32'(done_valid_o), 0);
        chk("rst_outstanding", 32'(outstanding_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done_instr", done_instruction_o, 0);
        chk("rst_done_tag", 32'(done_tag_o), 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            instruction_i       = tbl[i].instr;
            instruction_valid_i = tbl[i].vld;
            done_ready_i        = tbl[i].drdy;
            @(posedge clk_i); #1;
            chk($sformatf("tbl%0d_done_valid", i), 32'(done_valid_o), 32'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_outstanding", i), 32'(outstanding_o), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_out != 0));
            if (tbl[i].e_dv) begin
                chk($sformatf("tbl%0d_tag", i), 32'(done_tag_o), 32'(tbl[i].e_tag));
                chk($sformatf("tbl%0d_instr", i), done_instruction_o, tbl[i].e_instr);
            end
        end

        // Streaming stores with continuous retire: 3 in flight, tags wrap 15->0.
        do_reset();
        done_ready_i = 1'b1;
        exp_tag = 0;
        retired = 0;
        for (int c = 0; c < 40; c++) begin
            instruction_valid_i = (c < 20);
            instruction_i       = {16'(c), 16'h0002};
            @(posedge clk_i); #1;
            if (done_valid_o) begin
                chk($sformatf("stream_tag%0d", retired), 32'(done_tag_o), 32'(exp_tag));
                chk($sformatf("stream_instr%0d", retired), done_instruction_o, {16'(retired), 16'h0002});
                exp_tag = (exp_tag + 1) % 16;
                retired++;
            end
            if (c >= 2 && c < 20) chk($sformatf("stream_out_c%0d", c), 32'(outstanding_o), 3);
            if (c < 20) chk($sformatf("stream_ready_c%0d", c), 32'(ready_o), 1);
        end
        chk("stream_retired", 32'(retired), 20);
        chk("stream_empty", 32'(outstanding_o), 0);

        // Reset with work in flight: immediate clear, no stale done, tags restart.
        do_reset();
        done_ready_i = 1'b1;
        instruction_i = 32'h0000_EE01;
        instruction_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 instruction_valid_i = 1'b0;
        chk("mid_outstanding_pre", 32'(outstanding_o), 3);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready_o), 1);
        chk("mid_rst_done_valid", 32'(done_valid_o), 0);
        chk("mid_rst_outstanding", 32'(outstanding_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            if (done_valid_o) seen = 1;
        end
        chk("mid_no_stale_done", 32'(seen), 0);
        instruction_i = 32'h0000_7702;
        instruction_valid_i = 1'b1;
        @(posedge clk_i); #1 instruction_valid_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk_i); #1;
            if (done_valid_o) begin
                seen = 1;
                chk("post_rst_tag", 32'(done_tag_o), 0);
                chk("post_rst_instr", done_instruction_o, 32'h0000_7702);
            end
        end
        chk("post_rst_done_seen", 32'(seen), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
